// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the register-file writeback port arbiter.
package wb_port_arbiter_pkg;

    // Default register-file geometry.
    localparam int WB_DATA_W = 48;
    localparam int WB_ADDR_W = 5;

    // Register 0 is hard-wired; writes to it are accepted and dropped.
    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Writeback source indices as wired at the top of the core.
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MUL = 2;

    // Default width of the register-0 discard counter.
    localparam int WB_CNT_W = 16;

endpackage : wb_port_arbiter_pkg

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps
// modulo NUM_REQ. The first requester found wins. The grant is gated by en_i,
// but idx_o/any_o still report the winner so the caller can qualify it.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Walk the request vector from the pointer and pick the first valid entry.
    always_comb begin : search
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // The sum is one bit wider than the index so ptr + k cannot wrap
            // before the modulo correction.
            sum = (IDX_W+1)'(ptr_i) + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = en_i;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. NUM_REQ writeback sources compete
// round-robin for the single write port. The granted write is registered and
// presented for one cycle. Writes to register 0 are dropped and counted.
//
// Handshake: a requester presents req_valid with a stable addr/data. A
// transfer happens in the cycle where req_valid[i] and req_ready[i] are both
// high. req_ready is combinational, one-hot-or-zero, and is held low during
// reset and wb_stall.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = WB_DATA_W,
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int CNT_W   = WB_CNT_W,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_stall,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]         rf_data,
    output logic [PTR_W-1:0]          rr_ptr,
    output logic [CNT_W-1:0]          zero_discard_cnt
);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic               grant_en;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   win_idx;
    logic               any_req;
    logic               xfer;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    // Unpack the flat request buses so the winner can be selected by index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    assign grant_en = !wb_stall && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (PTR_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (grant_en),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (any_req)
    );

    assign req_ready = gnt;
    assign xfer      = any_req && grant_en;
    assign win_addr  = addr_arr[win_idx];
    assign win_data  = data_arr[win_idx];

    // Next-state: the pointer advances past the winner on every transfer,
    // including register-0 writes. Otherwise the output stage only pulses.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        cnt_d     = cnt_q;
        if (xfer) begin
            rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (win_addr == ADDR_W'(REG_ZERO)) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                rf_we_d   = 1'b1;
                rf_addr_d = win_addr;
                rf_data_d = win_data;
            end
        end
    end

    // State registers. Reset drops any write that is still registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rr_ptr           = rr_ptr_q;
    assign rf_we            = rf_we_q;
    assign rf_addr          = rf_addr_q;
    assign rf_data          = rf_data_q;
    assign zero_discard_cnt = cnt_q;

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by randomized traffic,
// all compared against a cycle-level behavioural model.
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 48;
    localparam int CW = 16;
    localparam int PW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            wb_stall;
    logic            rf_we;
    logic [AW-1:0]   rf_addr;
    logic [DW-1:0]   rf_data;
    logic [PW-1:0]   rr_ptr;
    logic [CW-1:0]   zero_discard_cnt;

    wb_port_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .CNT_W   (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .wb_stall         (wb_stall),
        .rf_we            (rf_we),
        .rf_addr          (rf_addr),
        .rf_data          (rf_data),
        .rr_ptr           (rr_ptr),
        .zero_discard_cnt (zero_discard_cnt)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- requester state ----------------
    logic          v [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];

    // ---------------- behavioural model ----------------
    int            m_ptr;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_cnt;

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0;
            a[i] = '0;
            d[i] = '0;
        end
    endtask

    // One clock cycle: drive inputs (called at negedge), check the
    // combinational grant, advance the model at posedge, check the registered
    // outputs at the following negedge.
    task automatic step(output int granted);
        int w;
        logic [N-1:0] exp_ready;
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = v[i];
            req_addr[i*AW +: AW]   = a[i];
            req_data[i*DW +: DW]   = d[i];
        end
        #1;
        w = model_winner();
        exp_ready = '0;
        granted = -1;
        if (w >= 0 && !wb_stall && !reset) begin
            exp_ready[w] = 1'b1;
            granted = w;
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
        end else if (granted >= 0) begin
            m_ptr = (granted + 1) % N;
            if (a[granted] == 0) begin
                m_we = 1'b0;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end else begin
                m_we   = 1'b1;
                m_addr = a[granted];
                m_data = d[granted];
            end
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
        check("rf_we",   64'(rf_we),            64'(m_we));
        check("rf_addr", 64'(rf_addr),          64'(m_addr));
        check("rf_data", 64'(rf_data),          64'(m_data));
        check("rr_ptr",  64'(rr_ptr),           64'(m_ptr));
        check("cnt",     64'(zero_discard_cnt), 64'(m_cnt));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g;
        m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
        reset = 1'b1;
        wb_stall = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        clear_reqs();
        @(negedge clk);

        // Reset with a pending request: nothing may be granted.
        v[1] = 1'b1; a[1] = 5'd3; d[1] = 48'h1;
        step(g);
        step(g);
        reset = 1'b0;
        clear_reqs();
        step(g);

        // Single write from requester 1.
        v[1] = 1'b1; a[1] = 5'd7; d[1] = 48'h0000_1234_5678;
        step(g);
        check("t1_we",   64'(rf_we),   64'd1);
        check("t1_addr", 64'(rf_addr), 64'd7);
        check("t1_data", 64'(rf_data), 64'h0000_1234_5678);
        v[1] = 1'b0;
        step(g);
        check("t1_we_off", 64'(rf_we),  64'd0);
        check("t1_ptr",    64'(rr_ptr), 64'd2);

        // Back-to-back grants from pointer 0.
        reset = 1'b1; step(g); reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = DW'(48'hA000 + i);
        end
        for (int k = 0; k < 6; k++) begin
            step(g);
            check("b2b_we",   64'(rf_we),   64'd1);
            check("b2b_addr", 64'(rf_addr), 64'((k % 3) + 1));
        end
        clear_reqs();

        // Register-0 write from requester 2 (pointer is 0, only 2 is valid).
        v[2] = 1'b1; a[2] = 5'd0; d[2] = 48'hFFFF_FFFF_FFFF;
        step(g);
        check("z_we",  64'(rf_we),            64'd0);
        check("z_cnt", 64'(zero_discard_cnt), 64'd1);
        check("z_ptr", 64'(rr_ptr),           64'd0);
        clear_reqs();

        // Stall for 4 cycles with requesters 0 and 1 waiting.
        v[0] = 1'b1; a[0] = 5'd9;  d[0] = 48'h900;
        v[1] = 1'b1; a[1] = 5'd10; d[1] = 48'hA00;
        wb_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(g);
            check("stall_ptr", 64'(rr_ptr), 64'd0);
        end
        wb_stall = 1'b0;
        step(g);
        check("unstall_addr", 64'(rf_addr), 64'd9);
        clear_reqs();

        // Grant followed by reset on the next edge.
        v[0] = 1'b1; a[0] = 5'd5; d[0] = 48'h55;
        step(g);
        v[0] = 1'b0;
        reset = 1'b1;
        v[1] = 1'b1; a[1] = 5'd6; d[1] = 48'h66;
        step(g);
        check("rst_we",   64'(rf_we),   64'd0);
        check("rst_addr", 64'(rf_addr), 64'd0);
        reset = 1'b0;
        clear_reqs();

        // Saturate the discard counter.
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = 5'd0; d[i] = DW'(i);
        end
        for (int k = 0; k < 65540; k++) step(g);
        check("sat_cnt", 64'(zero_discard_cnt), 64'hFFFF);
        clear_reqs();

        // Randomized traffic: requesters hold valid until granted.
        reset = 1'b1; step(g); reset = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i] = 1'b1;
                    a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, 31));
                    d[i] = DW'({$urandom(), $urandom()});
                end
            end
            wb_stall = ($urandom_range(0, 4) == 0);
            reset    = ($urandom_range(0, 49) == 0);
            step(g);
            if (g >= 0) v[g] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_wb_port_arbiter
